buffet_sram_ctrl: RTL and testbench

//  Buffet controller directly upstream of the 2048x16 dual-port SRAM macro; it drives both macro ports.

---
 rtl/buffet_pkg.sv | 12 +
 rtl/buffet_rd_skid.sv | 51 +++++
 rtl/buffet_sram_ctrl.sv | 127 ++++++++++++
 tb/tb_buffet_sram_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffet_pkg.sv
// Shared sizing and types for the buffet controller and its 2048x16 dual-port SRAM macro.
package buffet_pkg;

    localparam int unsigned DEPTH = 2048;
    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 16;

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   occ_t;
    typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/buffet_rd_skid.sv
// Two-entry in-order skid for port-B read data; tracks the one-cycle in-flight read token.
module buffet_rd_skid
    import buffet_pkg::*;
(
    input  logic          clk,
    input  logic          nreset_i,
    input  logic          in_fire,
    input  logic [DW-1:0] in_data,
    output logic          space,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic       inflight;
    logic [1:0] count;
    logic       wptr;
    logic       rptr;
    data_t      mem [2];
    logic       push;
    logic       pop;

    // Data from the macro arrives exactly one cycle after the read fire.
    assign push      = inflight;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rptr];
    assign space     = (({1'b0, inflight} + count) < 2'd2);

    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            inflight <= 1'b0;
            count    <= 2'd0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            inflight <= in_fire;
            if (push) begin
                mem[wptr] <= in_data;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/buffet_sram_ctrl.sv
// Buffet controller: circular-buffer head/tail/occupancy over a dual-port SRAM macro,
// port A for fills and updates, port B for head-relative reads returned through a skid.
module buffet_sram_ctrl
    import buffet_pkg::*;
(
    input  logic          clk,
    input  logic          nreset_i,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [DW-1:0] push_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_idx,
    input  logic          rd_will_update,
    output logic          rdat_valid,
    input  logic          rdat_ready,
    output logic [DW-1:0] rdat,
    input  logic          upd_valid,
    output logic          upd_ready,
    input  logic [DW-1:0] upd_data,
    input  logic          shr_valid,
    output logic          shr_ready,
    input  logic [AW:0]   shr_num,
    output logic [AW:0]   occupancy,
    output logic          sram_cen_a,
    output logic          sram_cen_b,
    output logic          sram_rdwen_a,
    output logic          sram_rdwen_b,
    output logic [AW-1:0] sram_a_a,
    output logic [AW-1:0] sram_a_b,
    output logic [DW-1:0] sram_d_a,
    output logic [DW-1:0] sram_d_b,
    input  logic [DW-1:0] sram_q_b
);

    localparam occ_t OCC_FULL = occ_t'(DEPTH);

    addr_t head;
    addr_t tail;
    occ_t  occ;
    logic  pend;
    addr_t pend_idx;
    addr_t pend_addr;
    logic  skid_space;
    logic  push_fire;
    logic  rd_fire;
    logic  upd_fire;
    logic  shr_fire;

    // Readiness; reset forces every ready low. Update takes port A ahead of a fill.
    assign upd_ready  = nreset_i && pend;
    assign upd_fire   = upd_valid && upd_ready;
    assign push_ready = nreset_i && (occ != OCC_FULL) && !upd_fire;
    assign push_fire  = push_valid && push_ready;
    assign rd_ready   = nreset_i && ({1'b0, rd_idx} < occ)
                        && !(pend && (rd_idx == pend_idx))
                        && !(rd_will_update && pend) && skid_space;
    assign rd_fire    = rd_valid && rd_ready;
    assign shr_ready  = nreset_i && (shr_num <= occ) && !pend;
    assign shr_fire   = shr_valid && shr_ready;
    assign occupancy  = occ;
    assign sram_d_b   = '0;

    // Macro controls decode straight from the fire strobes.
    always_comb begin
        sram_cen_a   = 1'b1;
        sram_rdwen_a = 1'b1;
        sram_a_a     = '0;
        sram_d_a     = '0;
        sram_cen_b   = 1'b1;
        sram_rdwen_b = 1'b1;
        sram_a_b     = '0;
        if (upd_fire) begin
            sram_cen_a   = 1'b0;
            sram_rdwen_a = 1'b0;
            sram_a_a     = pend_addr;
            sram_d_a     = upd_data;
        end else if (push_fire) begin
            sram_cen_a   = 1'b0;
            sram_rdwen_a = 1'b0;
            sram_a_a     = tail;
            sram_d_a     = push_data;
        end
        if (rd_fire) begin
            sram_cen_b = 1'b0;
            sram_a_b   = head + rd_idx;
        end
    end

    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            pend      <= 1'b0;
            pend_idx  <= '0;
            pend_addr <= '0;
        end else begin
            if (push_fire) begin
                tail <= tail + addr_t'(1);
            end
            if (shr_fire) begin
                head <= head + addr_t'(shr_num);
            end
            occ <= occ + occ_t'(push_fire) - (shr_fire ? shr_num : occ_t'(0));
            if (upd_fire) begin
                pend <= 1'b0;
            end else if (rd_fire && rd_will_update) begin
                pend      <= 1'b1;
                pend_idx  <= rd_idx;
                pend_addr <= head + rd_idx;
            end
        end
    end

    buffet_rd_skid u_skid (
        .clk       (clk),
        .nreset_i  (nreset_i),
        .in_fire   (rd_fire),
        .in_data   (sram_q_b),
        .space     (skid_space),
        .out_valid (rdat_valid),
        .out_ready (rdat_ready),
        .out_data  (rdat)
    );

endmodule

// File: tb/tb_buffet_sram_ctrl.sv
// Scoreboard bench for buffet_sram_ctrl with a behavioural 2048x16 dual-port macro.
module tb_buffet_sram_ctrl;
    import buffet_pkg::*;

    logic  clk = 1'b0;
    logic  nreset_i;
    logic  push_valid, push_ready;
    data_t push_data;
    logic  rd_valid, rd_ready, rd_will_update;
    addr_t rd_idx;
    logic  rdat_valid, rdat_ready;
    data_t rdat;
    logic  upd_valid, upd_ready;
    data_t upd_data;
    logic  shr_valid, shr_ready;
    occ_t  shr_num;
    occ_t  occupancy;
    logic  sram_cen_a, sram_cen_b, sram_rdwen_a, sram_rdwen_b;
    addr_t sram_a_a, sram_a_b;
    data_t sram_d_a, sram_d_b, sram_q_b;

    int    vectors = 0;
    int    errors  = 0;
    data_t sb [$];
    data_t macro_mem [DEPTH];

    always #5 clk = ~clk;

    buffet_sram_ctrl dut (
        .clk(clk), .nreset_i(nreset_i),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx), .rd_will_update(rd_will_update),
        .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat(rdat),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_data(upd_data),
        .shr_valid(shr_valid), .shr_ready(shr_ready), .shr_num(shr_num),
        .occupancy(occupancy),
        .sram_cen_a(sram_cen_a), .sram_cen_b(sram_cen_b),
        .sram_rdwen_a(sram_rdwen_a), .sram_rdwen_b(sram_rdwen_b),
        .sram_a_a(sram_a_a), .sram_a_b(sram_a_b),
        .sram_d_a(sram_d_a), .sram_d_b(sram_d_b), .sram_q_b(sram_q_b)
    );

    // Macro model: synchronous write on A, one-cycle read on B.
    always @(posedge clk) begin
        if (!sram_cen_a && !sram_rdwen_a) macro_mem[sram_a_a] <= sram_d_a;
        if (!sram_cen_b && sram_rdwen_b)  sram_q_b <= macro_mem[sram_a_b];
    end

    // Monitor: every accepted read-data beat is popped from the scoreboard.
    always @(negedge clk) begin
        if (nreset_i && rdat_valid && rdat_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rdat_unexpected: got %04h with empty scoreboard", rdat);
            end else begin
                data_t e;
                e = sb.pop_front();
                if (rdat !== e) begin
                    errors++;
                    $display("FAIL rdat: got %04h want %04h", rdat, e);
                end
            end
        end
        if (!sram_cen_a && !sram_rdwen_a && !sram_cen_b && (sram_a_a == sram_a_b)) begin
            vectors++;
            errors++;
            $display("FAIL port_collision: both ports at address %0d", sram_a_a);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: ready never asserted", name);
    endtask

    task automatic do_push(input data_t d);
        int n = 0;
        push_valid = 1'b1;
        push_data  = d;
        @(negedge clk);
        while (!push_ready && n < 64) begin @(negedge clk); n++; end
        if (!push_ready) timeout("push_wait");
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic do_read(input addr_t idx, input logic wu, input data_t exp);
        int n = 0;
        rd_valid = 1'b1;
        rd_idx = idx;
        rd_will_update = wu;
        @(negedge clk);
        while (!rd_ready && n < 64) begin @(negedge clk); n++; end
        if (!rd_ready) timeout("read_wait");
        else sb.push_back(exp);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        rd_will_update = 1'b0;
    endtask

    task automatic do_shrink(input occ_t num);
        int n = 0;
        shr_valid = 1'b1;
        shr_num = num;
        @(negedge clk);
        while (!shr_ready && n < 64) begin @(negedge clk); n++; end
        if (!shr_ready) timeout("shrink_wait");
        @(posedge clk); #1;
        shr_valid = 1'b0;
        shr_num = '0;
    endtask

    task automatic do_update(input data_t d);
        int n = 0;
        upd_valid = 1'b1;
        upd_data = d;
        @(negedge clk);
        while (!upd_ready && n < 64) begin @(negedge clk); n++; end
        if (!upd_ready) timeout("update_wait");
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
        #1;
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset_i = 1'b0;
        push_valid = 1'b0; push_data = '0;
        rd_valid = 1'b0; rd_idx = '0; rd_will_update = 1'b0;
        rdat_ready = 1'b1;
        upd_valid = 1'b0; upd_data = '0;
        shr_valid = 1'b0; shr_num = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_push_ready", 32'(push_ready), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd0);
        check("rst_upd_ready", 32'(upd_ready), 32'd0);
        check("rst_shr_ready", 32'(shr_ready), 32'd0);
        check("rst_cen", 32'({sram_cen_a, sram_cen_b}), 32'd3);
        check("rst_rdat_valid", 32'(rdat_valid), 32'd0);
        @(posedge clk); #1;
        nreset_i = 1'b1;
        @(negedge clk);
        check("post_rst_push_ready", 32'(push_ready), 32'd1);
        check("post_rst_rd_ready", 32'(rd_ready), 32'd0);
        @(posedge clk); #1;

        // Full buffer
        for (int unsigned i = 0; i < DEPTH; i++) do_push(data_t'(i));
        @(negedge clk);
        check("full_occ", 32'(occupancy), 32'd2048);
        check("full_push_ready", 32'(push_ready), 32'd0);
        @(posedge clk); #1;
        do_read(addr_t'(5), 1'b0, 16'd5);
        do_read(addr_t'(2047), 1'b0, 16'd2047);
        drain();
        do_shrink(occ_t'(2048));
        @(negedge clk);
        check("empty_occ", 32'(occupancy), 32'd0);
        check("empty_rd_ready", 32'(rd_ready), 32'd0);
        shr_num = occ_t'(1);
        #1;
        check("empty_shr1_ready", 32'(shr_ready), 32'd0);
        @(posedge clk); #1;
        do_shrink(occ_t'(0));
        @(negedge clk);
        check("shr0_occ", 32'(occupancy), 32'd0);
        @(posedge clk); #1;

        // Wrap: head ends at 2040, tail wraps to 8
        for (int unsigned i = 0; i < 2040; i++) do_push(16'h1000 + data_t'(i));
        do_shrink(occ_t'(2040));
        for (int unsigned i = 0; i < 16; i++) do_push(16'h2000 + data_t'(i));
        do_read(addr_t'(10), 1'b0, 16'h200A);
        drain();
        check("wrap_mem_addr2", 32'(macro_mem[2]), 32'h200A);

        // Reservation and update
        do_read(addr_t'(3), 1'b1, 16'h2003);
        rd_idx = addr_t'(3); shr_num = occ_t'(1);
        @(negedge clk);
        check("pend_rd_ready_idx3", 32'(rd_ready), 32'd0);
        check("pend_shr_ready", 32'(shr_ready), 32'd0);
        check("pend_upd_ready", 32'(upd_ready), 32'd1);
        @(posedge clk); #1;
        rd_idx = addr_t'(4); rd_will_update = 1'b1;
        @(negedge clk);
        check("pend_rd_ready_wu", 32'(rd_ready), 32'd0);
        @(posedge clk); #1;
        rd_will_update = 1'b0;
        @(negedge clk);
        check("pend_rd_ready_idx4", 32'(rd_ready), 32'd1);
        @(posedge clk); #1;
        shr_num = '0;
        do_update(16'hBEEF);
        do_read(addr_t'(3), 1'b0, 16'hBEEF);
        drain();
        do_shrink(occ_t'(16));
        @(negedge clk);
        check("upd_shrink_occ", 32'(occupancy), 32'd0);
        @(posedge clk); #1;

        // Backpressure through the skid
        for (int unsigned i = 0; i < 4; i++) do_push(16'h3000 + data_t'(i));
        rdat_ready = 1'b0;
        do_read(addr_t'(0), 1'b0, 16'h3000);
        do_read(addr_t'(1), 1'b0, 16'h3001);
        rd_valid = 1'b1; rd_idx = addr_t'(2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_rd_ready", 32'(rd_ready), 32'd0);
            check("bp_rdat_hold", 32'({rdat_valid, rdat}), 32'h13000);
            @(posedge clk);
        end
        #1;
        rd_valid = 1'b0;
        rdat_ready = 1'b1;
        do_read(addr_t'(2), 1'b0, 16'h3002);
        drain();

        // Fill and shrink(1) in the same cycle at occupancy 4
        push_valid = 1'b1; push_data = 16'h4000;
        shr_valid = 1'b1; shr_num = occ_t'(1);
        @(negedge clk);
        check("fs_push_ready", 32'(push_ready), 32'd1);
        check("fs_shr_ready", 32'(shr_ready), 32'd1);
        @(posedge clk); #1;
        push_valid = 1'b0; shr_valid = 1'b0; shr_num = '0;
        @(negedge clk);
        check("fs_occ", 32'(occupancy), 32'd4);
        @(posedge clk); #1;

        // Update and fill in the same cycle
        do_read(addr_t'(0), 1'b1, 16'h3001);
        upd_valid = 1'b1; upd_data = 16'hCAFE;
        push_valid = 1'b1; push_data = 16'h4001;
        @(negedge clk);
        check("uf_upd_ready", 32'(upd_ready), 32'd1);
        check("uf_push_ready", 32'(push_ready), 32'd0);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        @(negedge clk);
        check("uf_occ_after_upd", 32'(occupancy), 32'd4);
        check("uf_push_ready_next", 32'(push_ready), 32'd1);
        @(posedge clk); #1;
        push_valid = 1'b0;
        @(negedge clk);
        check("uf_occ_after_fill", 32'(occupancy), 32'd5);
        @(posedge clk); #1;
        do_read(addr_t'(0), 1'b0, 16'hCAFE);
        do_read(addr_t'(4), 1'b0, 16'h4001);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
